// File: rtl/mult_pipe_fu.sv
// Pipelined 64-bit multiply unit: adds one opb slice to the partial product per stage.
// Latency STAGES cycles from issue; result held until mult_cdb_grant retires it.
// Backpressure: a held, ungranted result freezes every stage; mult_available follows.
`ifndef PRN_SIZE
`define PRN_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

module mult_pipe_fu #(
    parameter int STAGES = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          mult_issue_valid,
    input  logic [63:0]                   mult_opa_in,
    input  logic [63:0]                   mult_opb_in,
    input  logic                          mult_func_in,
    input  logic [$clog2(`PRN_SIZE)-1:0]  mult_dest_tag_in,
    input  logic [$clog2(`ROB_SIZE)-1:0]  mult_rob_idx_in,
    input  logic                          mult_cdb_grant,
    input  logic                          mult_flush,
    output logic                          mult_available,
    output logic                          mult_result_valid,
    output logic [63:0]                   mult_result_out,
    output logic [$clog2(`PRN_SIZE)-1:0]  mult_dest_tag_out,
    output logic [$clog2(`ROB_SIZE)-1:0]  mult_rob_idx_out
);
    localparam int W     = 64 / STAGES;
    localparam int TAG_W = $clog2(`PRN_SIZE);
    localparam int ROB_W = $clog2(`ROB_SIZE);

    typedef struct packed {
        logic              valid;
        logic [63:0]       opa;
        logic [63:0]       opb;
        logic              func;
        logic [TAG_W-1:0]  tag;
        logic [ROB_W-1:0]  rob;
        logic [127:0]      prod;
    } stage_t;

    stage_t s_q [STAGES];
    stage_t s_d [STAGES];
    logic   advance;

    // Slice k of opb contributes a*b_k aligned to bit k*W of the full product.
    function automatic logic [127:0] slice_pp(input logic [63:0] a, input logic [W-1:0] b,
                                              input int k);
        logic [127:0] p;
        p = {64'b0, a} * {{(128-W){1'b0}}, b};
        return p << (k * W);
    endfunction

    assign advance           = !s_q[STAGES-1].valid || mult_cdb_grant;
    assign mult_available    = advance;
    assign mult_result_valid = s_q[STAGES-1].valid;
    assign mult_result_out   = s_q[STAGES-1].func ? s_q[STAGES-1].prod[127:64]
                                                  : s_q[STAGES-1].prod[63:0];
    assign mult_dest_tag_out = s_q[STAGES-1].tag;
    assign mult_rob_idx_out  = s_q[STAGES-1].rob;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_q[k];
        end
        if (advance) begin
            s_d[0].valid = mult_issue_valid;
            s_d[0].opa   = mult_opa_in;
            s_d[0].opb   = mult_opb_in;
            s_d[0].func  = mult_func_in;
            s_d[0].tag   = mult_dest_tag_in;
            s_d[0].rob   = mult_rob_idx_in;
            s_d[0].prod  = slice_pp(mult_opa_in, mult_opb_in[W-1:0], 0);
            for (int k = 1; k < STAGES; k++) begin
                s_d[k]      = s_q[k-1];
                s_d[k].prod = s_q[k-1].prod + slice_pp(s_q[k-1].opa, s_q[k-1].opb[k*W +: W], k);
            end
        end
        // Flush wins over both issue and grant; data fields are left as don't-care.
        if (mult_flush) begin
            for (int k = 0; k < STAGES; k++) begin
                s_d[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_d[k];
            end
        end
    end
endmodule

// File: tb/tb_mult_pipe_fu.sv
// Directed bench for mult_pipe_fu with an in-order result queue as reference model.
`ifndef PRN_SIZE
`define PRN_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

module tb_mult_pipe_fu;
    localparam int STAGES = 4;
    localparam int TAG_W  = $clog2(`PRN_SIZE);
    localparam int ROB_W  = $clog2(`ROB_SIZE);

    logic              clock;
    logic              reset;
    logic              mult_issue_valid;
    logic [63:0]       mult_opa_in;
    logic [63:0]       mult_opb_in;
    logic              mult_func_in;
    logic [TAG_W-1:0]  mult_dest_tag_in;
    logic [ROB_W-1:0]  mult_rob_idx_in;
    logic              mult_cdb_grant;
    logic              mult_flush;
    logic              mult_available;
    logic              mult_result_valid;
    logic [63:0]       mult_result_out;
    logic [TAG_W-1:0]  mult_dest_tag_out;
    logic [ROB_W-1:0]  mult_rob_idx_out;

    mult_pipe_fu #(.STAGES(STAGES)) dut (
        .clock             (clock),
        .reset             (reset),
        .mult_issue_valid  (mult_issue_valid),
        .mult_opa_in       (mult_opa_in),
        .mult_opb_in       (mult_opb_in),
        .mult_func_in      (mult_func_in),
        .mult_dest_tag_in  (mult_dest_tag_in),
        .mult_rob_idx_in   (mult_rob_idx_in),
        .mult_cdb_grant    (mult_cdb_grant),
        .mult_flush        (mult_flush),
        .mult_available    (mult_available),
        .mult_result_valid (mult_result_valid),
        .mult_result_out   (mult_result_out),
        .mult_dest_tag_out (mult_dest_tag_out),
        .mult_rob_idx_out  (mult_rob_idx_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
        logic [ROB_W-1:0] rob;
    } exp_t;

    exp_t q[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic f,
                                   input logic [TAG_W-1:0] t, input logic [ROB_W-1:0] r);
        logic [127:0] full;
        exp_t e;
        full  = {64'b0, a} * {64'b0, b};
        e.res = f ? full[127:64] : full[63:0];
        e.tag = t;
        e.rob = r;
        return e;
    endfunction

    // Inputs change 1ns after a rising edge, so mid-cycle they describe the coming edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (mult_issue_valid)
                check("issue_while_unavailable", 64'(mult_available), 64'd1);
            if (mult_result_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_result_valid", 64'(mult_result_valid), 64'd0);
                end else begin
                    check("sb_result", mult_result_out, q[0].res);
                    check("sb_tag", 64'(mult_dest_tag_out), 64'(q[0].tag));
                    check("sb_rob", 64'(mult_rob_idx_out), 64'(q[0].rob));
                end
            end
            if (mult_flush) begin
                q.delete();
            end else begin
                if (mult_result_valid && mult_cdb_grant && q.size() > 0)
                    void'(q.pop_front());
                if (mult_issue_valid)
                    q.push_back(model(mult_opa_in, mult_opb_in, mult_func_in,
                                      mult_dest_tag_in, mult_rob_idx_in));
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_issue(input logic [63:0] a, input logic [63:0] b, input logic f,
                             input logic [TAG_W-1:0] t, input logic [ROB_W-1:0] r);
        mult_issue_valid = 1'b1;
        mult_opa_in      = a;
        mult_opb_in      = b;
        mult_func_in     = f;
        mult_dest_tag_in = t;
        mult_rob_idx_in  = r;
    endtask

    task automatic do_issue(input logic [63:0] a, input logic [63:0] b, input logic f,
                            input logic [TAG_W-1:0] t, input logic [ROB_W-1:0] r);
        set_issue(a, b, f, t, r);
        tick();
        mult_issue_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!mult_result_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_out(input string name, input logic [63:0] r, input logic [TAG_W-1:0] t,
                             input logic [ROB_W-1:0] rb);
        check({name, "_valid"}, 64'(mult_result_valid), 64'd1);
        check({name, "_result"}, mult_result_out, r);
        check({name, "_tag"}, 64'(mult_dest_tag_out), 64'(t));
        check({name, "_rob"}, 64'(mult_rob_idx_out), 64'(rb));
    endtask

    int lat;
    logic [63:0] bp_exp [4];

    initial begin
        reset            = 1'b1;
        mult_issue_valid = 1'b0;
        mult_opa_in      = '0;
        mult_opb_in      = '0;
        mult_func_in     = 1'b0;
        mult_dest_tag_in = '0;
        mult_rob_idx_in  = '0;
        mult_cdb_grant   = 1'b1;
        mult_flush       = 1'b0;
        #2;
        check("reset_valid", 64'(mult_result_valid), 64'd0);
        check("reset_result", mult_result_out, 64'd0);
        check("reset_tag", 64'(mult_dest_tag_out), 64'd0);
        check("reset_rob", 64'(mult_rob_idx_out), 64'd0);
        check("reset_available", 64'(mult_available), 64'd1);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        tick();

        // Single op, grant tied high.
        do_issue(64'd3, 64'd5, 1'b0, 6'h20, 5'h10);
        wait_valid(lat);
        check("single_latency", 64'(lat), 64'(STAGES - 1));
        check_out("single", 64'hF, 6'h20, 5'h10);
        tick();
        check("single_one_cycle", 64'(mult_result_valid), 64'd0);

        // UMULH then MULQ of all-ones operands, back to back.
        set_issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'h01, 5'h01);
        tick();
        do_issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'h02, 5'h02);
        wait_valid(lat);
        check_out("umulh", 64'hFFFF_FFFF_FFFF_FFFE, 6'h01, 5'h01);
        tick();
        check_out("mulq_ones", 64'h0000_0000_0000_0001, 6'h02, 5'h02);
        tick();

        // Four back-to-back squares.
        for (int i = 0; i < 4; i++) begin
            set_issue(64'(i + 2), 64'(i + 2), 1'b0, 6'(8 + i), 5'(i));
            tick();
        end
        mult_issue_valid = 1'b0;
        check_out("b2b0", 64'd4, 6'd8, 5'd0);
        tick();
        check_out("b2b1", 64'd9, 6'd9, 5'd1);
        tick();
        check_out("b2b2", 64'd16, 6'd10, 5'd2);
        tick();
        check_out("b2b3", 64'd25, 6'd11, 5'd3);
        tick();
        check("b2b_drained", 64'(mult_result_valid), 64'd0);

        // Backpressure: fill the pipe with grant low, then release.
        bp_exp[0] = 64'd42; bp_exp[1] = 64'd72; bp_exp[2] = 64'd110; bp_exp[3] = 64'd156;
        mult_cdb_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(64'(6 + 2 * i), 64'(7 + 2 * i), 1'b0, 6'(1 + i), 5'(20 + i));
            tick();
        end
        mult_issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_available_low", 64'(mult_available), 64'd0);
            check_out("bp_hold", 64'd42, 6'd1, 5'd20);
            tick();
        end
        check_out("bp_hold_last", 64'd42, 6'd1, 5'd20);
        mult_cdb_grant = 1'b1;
        #1;
        check("bp_available_comb", 64'(mult_available), 64'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_out("bp_drain", bp_exp[i], 6'(1 + i), 5'(20 + i));
        end
        tick();
        check("bp_drained", 64'(mult_result_valid), 64'd0);

        // Flush with two ops in flight plus a same-cycle issue.
        do_issue(64'd11, 64'd12, 1'b0, 6'h05, 5'h05);
        do_issue(64'd13, 64'd14, 1'b0, 6'h06, 5'h06);
        set_issue(64'd15, 64'd16, 1'b0, 6'h07, 5'h07);
        mult_flush = 1'b1;
        tick();
        mult_flush       = 1'b0;
        mult_issue_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("flush_no_valid", 64'(mult_result_valid), 64'd0);
            tick();
        end
        do_issue(64'd7, 64'd6, 1'b0, 6'h09, 5'h09);
        wait_valid(lat);
        check("post_flush_latency", 64'(lat), 64'(STAGES - 1));
        check_out("post_flush", 64'd42, 6'h09, 5'h09);
        tick();

        // Asynchronous reset mid-cycle with two ops in flight.
        do_issue(64'd100, 64'd3, 1'b0, 6'h0A, 5'h0A);
        do_issue(64'd200, 64'd3, 1'b0, 6'h0B, 5'h0B);
        tick();
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        check("rst_mid_valid", 64'(mult_result_valid), 64'd0);
        check("rst_mid_result", mult_result_out, 64'd0);
        check("rst_mid_tag", 64'(mult_dest_tag_out), 64'd0);
        check("rst_mid_rob", 64'(mult_rob_idx_out), 64'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("rst_release_available", 64'(mult_available), 64'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rst_no_stale", 64'(mult_result_valid), 64'd0);
        end

        check("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
